// File: rtl/cache_miss_fill_controller.sv
// cache_miss_fill_controller
// Sits in front of a fully-associative tag table. A request goes through a
// tag lookup. A hit returns the block location. A miss runs this sequence:
// invalidate the FIFO victim, fetch the block one word at a time into cache
// data memory, write the new tag, then report the location.
// Optional build macro: CACHE_MISS_STATS_EN adds saturating hit/miss counters.
module cache_miss_fill_controller #(
   parameter int BW_ADDR_SPACE        = 16,
   parameter int CACHE_BLOCK_CAPACITY = 4,
   parameter int WORDS_PER_BLOCK      = 4,
   parameter int BW_DATA              = 32,
   localparam int BW_CACHE_ADDR       = $clog2(CACHE_BLOCK_CAPACITY),
   localparam int BW_WORDS_PER_BLOCK  = $clog2(WORDS_PER_BLOCK),
   localparam int BW_TAG              = BW_ADDR_SPACE - BW_WORDS_PER_BLOCK
) (
   input  logic                                        clock_i,
   input  logic                                        resetn_i,
   input  logic                                        req_i,
   input  logic [BW_ADDR_SPACE-1:0]                    req_addr_i,
   output logic                                        ready_o,
   output logic                                        done_o,
   output logic                                        hit_o,
   output logic [BW_CACHE_ADDR-1:0]                    cache_addr_o,
   output logic [BW_TAG-1:0]                           tag_search_o,
   input  logic                                        tbl_hit_i,
   input  logic [BW_CACHE_ADDR-1:0]                    tbl_addr_i,
   output logic                                        tbl_wren_o,
   output logic                                        tbl_rmen_o,
   output logic [BW_CACHE_ADDR-1:0]                    tbl_addr_o,
   output logic [BW_TAG-1:0]                           tbl_tag_o,
   output logic                                        mem_rd_req_o,
   output logic [BW_ADDR_SPACE-1:0]                    mem_addr_o,
   input  logic                                        mem_ack_i,
   input  logic [BW_DATA-1:0]                          mem_data_i,
   output logic                                        cache_wren_o,
   output logic [BW_CACHE_ADDR+BW_WORDS_PER_BLOCK-1:0] cache_waddr_o,
   output logic [BW_DATA-1:0]                          cache_wdata_o
`ifdef CACHE_MISS_STATS_EN
   ,
   output logic [BW_ADDR_SPACE-1:0]                    hit_count_o,
   output logic [BW_ADDR_SPACE-1:0]                    miss_count_o
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_EVICT  = 3'd2,
      S_FILL   = 3'd3,
      S_COMMIT = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                          state_q, state_d;
   logic [BW_TAG-1:0]               tag_q, tag_d;
   logic [BW_CACHE_ADDR-1:0]        victim_q, victim_d;
   logic [BW_WORDS_PER_BLOCK-1:0]   word_q, word_d;
   logic [BW_CACHE_ADDR-1:0]        loc_q, loc_d;
   logic                            hit_q, hit_d;

   // Word-offset bits of the request address only select a word inside the
   // block; the whole block is always fetched, so they are not needed here.
   logic unused_word_bits;
   assign unused_word_bits = ^req_addr_i[BW_WORDS_PER_BLOCK-1:0];

   assign tag_search_o = tag_q;

   // State and datapath registers; reset aborts any transfer in flight.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q  <= S_IDLE;
         tag_q    <= '0;
         victim_q <= '0;
         word_q   <= '0;
         loc_q    <= '0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         victim_q <= victim_d;
         word_q   <= word_d;
         loc_q    <= loc_d;
         hit_q    <= hit_d;
      end
   end

   // Next-state and output decode; every enable is zero outside its state.
   always_comb begin
      state_d       = state_q;
      tag_d         = tag_q;
      victim_d      = victim_q;
      word_d        = word_q;
      loc_d         = loc_q;
      hit_d         = hit_q;
      ready_o       = 1'b0;
      done_o        = 1'b0;
      hit_o         = 1'b0;
      cache_addr_o  = '0;
      tbl_wren_o    = 1'b0;
      tbl_rmen_o    = 1'b0;
      tbl_addr_o    = '0;
      tbl_tag_o     = '0;
      mem_rd_req_o  = 1'b0;
      mem_addr_o    = '0;
      cache_wren_o  = 1'b0;
      cache_waddr_o = '0;
      cache_wdata_o = '0;
      case (state_q)
         S_IDLE: begin
            ready_o = 1'b1;
            if (req_i) begin
               tag_d   = req_addr_i[BW_ADDR_SPACE-1:BW_WORDS_PER_BLOCK];
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            hit_d = tbl_hit_i;
            if (tbl_hit_i) begin
               loc_d   = tbl_addr_i;
               state_d = S_DONE;
            end else begin
               state_d = S_EVICT;
            end
         end
         S_EVICT: begin
            tbl_rmen_o = 1'b1;
            tbl_addr_o = victim_q;
            word_d     = '0;
            state_d    = S_FILL;
         end
         S_FILL: begin
            mem_rd_req_o = 1'b1;
            mem_addr_o   = {tag_q, word_q};
            if (mem_ack_i) begin
               cache_wren_o  = 1'b1;
               cache_waddr_o = {victim_q, word_q};
               cache_wdata_o = mem_data_i;
               word_d        = word_q + BW_WORDS_PER_BLOCK'(1);
               if (word_q == BW_WORDS_PER_BLOCK'(WORDS_PER_BLOCK - 1))
                  state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            tbl_wren_o = 1'b1;
            tbl_addr_o = victim_q;
            tbl_tag_o  = tag_q;
            loc_d      = victim_q;
            // Capacity need not be a power of two, so wrap explicitly.
            if (victim_q == BW_CACHE_ADDR'(CACHE_BLOCK_CAPACITY - 1))
               victim_d = '0;
            else
               victim_d = victim_q + BW_CACHE_ADDR'(1);
            state_d = S_DONE;
         end
         S_DONE: begin
            done_o       = 1'b1;
            hit_o        = hit_q;
            cache_addr_o = loc_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef CACHE_MISS_STATS_EN
   logic [BW_ADDR_SPACE-1:0] hit_cnt_q, hit_cnt_d;
   logic [BW_ADDR_SPACE-1:0] miss_cnt_q, miss_cnt_d;

   // Saturating hit/miss tallies, bumped once per completed request.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == S_DONE) begin
         if (hit_q && !(&hit_cnt_q))
            hit_cnt_d = hit_cnt_q + BW_ADDR_SPACE'(1);
         if (!hit_q && !(&miss_cnt_q))
            miss_cnt_d = miss_cnt_q + BW_ADDR_SPACE'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_miss_fill_controller.sv
// Bench for cache_miss_fill_controller: an external tag table model and a
// memory responder feed the DUT. A cache-level reference model (contents +
// FIFO victim) predicts every request outcome.
module tb_cache_miss_fill_controller;
   localparam int AW  = 16;
   localparam int CAP = 4;
   localparam int WPB = 4;
   localparam int DW  = 32;
   localparam int CW  = 2;
   localparam int WW  = 2;
   localparam int TW  = AW - WW;

   logic              clock_i = 1'b0;
   logic              resetn_i = 1'b0;
   logic              req_i = 1'b0;
   logic [AW-1:0]     req_addr_i = '0;
   logic              ready_o, done_o, hit_o;
   logic [CW-1:0]     cache_addr_o;
   logic [TW-1:0]     tag_search_o;
   logic              tbl_hit_i;
   logic [CW-1:0]     tbl_addr_i;
   logic              tbl_wren_o, tbl_rmen_o;
   logic [CW-1:0]     tbl_addr_o;
   logic [TW-1:0]     tbl_tag_o;
   logic              mem_rd_req_o;
   logic [AW-1:0]     mem_addr_o;
   logic              mem_ack_i = 1'b0;
   logic [DW-1:0]     mem_data_i = '0;
   logic              cache_wren_o;
   logic [CW+WW-1:0]  cache_waddr_o;
   logic [DW-1:0]     cache_wdata_o;
`ifdef CACHE_MISS_STATS_EN
   logic [AW-1:0]     hit_count_o, miss_count_o;
`endif

   int checks = 0;
   int errors = 0;

   cache_miss_fill_controller dut (
      .clock_i(clock_i), .resetn_i(resetn_i), .req_i(req_i), .req_addr_i(req_addr_i),
      .ready_o(ready_o), .done_o(done_o), .hit_o(hit_o), .cache_addr_o(cache_addr_o),
      .tag_search_o(tag_search_o), .tbl_hit_i(tbl_hit_i), .tbl_addr_i(tbl_addr_i),
      .tbl_wren_o(tbl_wren_o), .tbl_rmen_o(tbl_rmen_o), .tbl_addr_o(tbl_addr_o),
      .tbl_tag_o(tbl_tag_o), .mem_rd_req_o(mem_rd_req_o), .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .cache_wren_o(cache_wren_o),
      .cache_waddr_o(cache_waddr_o), .cache_wdata_o(cache_wdata_o)
`ifdef CACHE_MISS_STATS_EN
      , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
   );

   always #5 clock_i = ~clock_i;

   // External fully-associative tag table (not affected by the DUT reset).
   logic [TW-1:0] m_tag [CAP] = '{default: '0};
   logic          m_vld [CAP] = '{default: 1'b0};

   always_comb begin
      tbl_hit_i  = 1'b0;
      tbl_addr_i = '0;
      for (int i = 0; i < CAP; i++)
         if (m_vld[i] && m_tag[i] == tag_search_o) begin
            tbl_hit_i  = 1'b1;
            tbl_addr_i = CW'(i);
         end
   end

   always @(posedge clock_i) begin
      if (tbl_rmen_o) m_vld[tbl_addr_o] <= 1'b0;
      if (tbl_wren_o) begin
         m_vld[tbl_addr_o] <= 1'b1;
         m_tag[tbl_addr_o] <= tbl_tag_o;
      end
   end

   // Reference model of the cache: which tag lives where, plus FIFO victim.
   logic [TW-1:0] ref_tag [CAP];
   bit            ref_vld [CAP];
   int            ref_victim = 0;
   int            ref_hits = 0;
   int            ref_misses = 0;

   task automatic drive_ack(input int gap, inout int gap_cnt);
      if (gap < 0) begin
         mem_ack_i = 1'($urandom_range(0, 1));
      end else if (gap_cnt == 0) begin
         mem_ack_i = 1'b1;
         gap_cnt   = gap;
      end else begin
         mem_ack_i = 1'b0;
         gap_cnt--;
      end
      mem_data_i = $urandom;
   endtask

   // One request end to end. gap: fixed idle cycles between acks (-1 random).
   // abort_at > 0: assert reset right after that many fill words were written.
   task automatic run_req(input logic [AW-1:0] addr, input int gap, input int abort_at);
      logic [TW-1:0] tag;
      bit  exp_hit;
      int  exp_loc, n, wcnt, rm_cnt, rm_n, wr_n, done_n, mem_first, gap_cnt;
      tag = addr[AW-1:WW];
      exp_hit = 1'b0;
      exp_loc = ref_victim;
      for (int i = 0; i < CAP; i++)
         if (ref_vld[i] && ref_tag[i] == tag) begin
            exp_hit = 1'b1;
            exp_loc = i;
         end
      wcnt = 0; rm_cnt = 0; rm_n = -1; wr_n = -1; done_n = -1; mem_first = -1;
      gap_cnt = (gap < 0) ? 0 : gap;

      @(posedge clock_i); #1;
      req_i = 1'b1;
      req_addr_i = addr;
      @(negedge clock_i);
      checks++;
      if (ready_o !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_req: got %b want 1", ready_o);
      end
      @(posedge clock_i); #1;
      req_i = 1'b0;
      req_addr_i = AW'($urandom);
      drive_ack(gap, gap_cnt);

      for (n = 1; n < 300; n++) begin
         @(negedge clock_i);
         if (tbl_rmen_o && tbl_wren_o) begin
            checks++; errors++;
            $display("FAIL tbl_both_en: cycle %0d rmen and wren both high", n);
         end
         if (tbl_rmen_o) begin
            rm_cnt++; rm_n = n;
            checks++;
            if (tbl_addr_o !== CW'(exp_loc)) begin
               errors++;
               $display("FAIL evict_addr: got %0d want %0d", tbl_addr_o, exp_loc);
            end
         end
         if (mem_rd_req_o) begin
            if (mem_first < 0) mem_first = n;
            checks++;
            if (mem_addr_o !== {tag, WW'(wcnt)}) begin
               errors++;
               $display("FAIL mem_addr: got %h want %h", mem_addr_o, {tag, WW'(wcnt)});
            end
         end
         if (cache_wren_o) begin
            checks++;
            if (!(mem_rd_req_o && mem_ack_i) || cache_waddr_o !== {CW'(exp_loc), WW'(wcnt)}
                || cache_wdata_o !== mem_data_i || wcnt >= WPB) begin
               errors++;
               $display("FAIL cache_write: addr %h data %h (ack %b) want addr %h data %h word %0d",
                        cache_waddr_o, cache_wdata_o, mem_ack_i, {CW'(exp_loc), WW'(wcnt)},
                        mem_data_i, wcnt);
            end
            wcnt++;
         end else if (mem_rd_req_o && mem_ack_i) begin
            checks++; errors++;
            $display("FAIL missing_write: ack in fill without cache write (word %0d)", wcnt);
         end
         if (tbl_wren_o) begin
            wr_n = n;
            checks++;
            if (tbl_addr_o !== CW'(exp_loc) || tbl_tag_o !== tag) begin
               errors++;
               $display("FAIL commit: addr %0d tag %h want addr %0d tag %h",
                        tbl_addr_o, tbl_tag_o, exp_loc, tag);
            end
         end
         if (done_o) begin
            done_n = n;
            break;
         end
         checks++;
         if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: cycle %0d ready %b want 0", n, ready_o);
         end
         if (abort_at > 0 && wcnt == abort_at) break;
         @(posedge clock_i); #1;
         drive_ack(gap, gap_cnt);
      end

      if (abort_at > 0) begin
         #1 resetn_i = 1'b0;
         #1;
         checks++;
         if (ready_o !== 1'b1 || {done_o, hit_o, cache_addr_o, tbl_wren_o, tbl_rmen_o, tbl_addr_o,
              tbl_tag_o, mem_rd_req_o, mem_addr_o, cache_wren_o, cache_waddr_o, cache_wdata_o,
              tag_search_o} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: ready %b done %b memreq %b wren %b memaddr %h want idle zeros",
                     ready_o, done_o, mem_rd_req_o, cache_wren_o, mem_addr_o);
         end
         ref_vld[exp_loc] = 1'b0;
         ref_victim = 0;
         ref_hits = 0;
         ref_misses = 0;
         @(posedge clock_i); #1;
         resetn_i  = 1'b1;
         mem_ack_i = 1'b1;
         mem_data_i = $urandom;
         @(negedge clock_i);
         checks++;
         if (cache_wren_o !== 1'b0 || mem_rd_req_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stray_ack: wren %b memreq %b ready %b want 0 0 1",
                     cache_wren_o, mem_rd_req_o, ready_o);
         end
         @(posedge clock_i); #1;
         mem_ack_i = 1'b0;
         return;
      end

      checks++;
      if (done_n < 0) begin
         errors++;
         $display("FAIL timeout: no done_o for addr %h", addr);
      end
      checks++;
      if (hit_o !== exp_hit || cache_addr_o !== CW'(exp_loc)) begin
         errors++;
         $display("FAIL result: addr %h hit %b loc %0d want hit %b loc %0d",
                  addr, hit_o, cache_addr_o, exp_hit, exp_loc);
      end
      checks++;
      if (exp_hit) begin
         if (done_n != 2 || rm_cnt != 0 || mem_first >= 0 || wcnt != 0 || wr_n >= 0) begin
            errors++;
            $display("FAIL hit_timing: done at %0d evicts %0d memreq %0d writes %0d want 2 0 none 0",
                     done_n, rm_cnt, mem_first, wcnt);
         end
         ref_hits++;
      end else begin
         if (rm_cnt != 1 || rm_n != 2 || mem_first != 3 || wcnt != WPB || wr_n != done_n - 1
             || done_n < 4 + WPB || (gap == 0 && done_n != 4 + WPB)) begin
            errors++;
            $display("FAIL miss_timing: evict %0dx at %0d fill %0d writes %0d commit %0d done %0d",
                     rm_cnt, rm_n, mem_first, wcnt, wr_n, done_n);
         end
         ref_tag[exp_loc] = tag;
         ref_vld[exp_loc] = 1'b1;
         ref_victim = (exp_loc + 1) % CAP;
         ref_misses++;
      end
      @(posedge clock_i); #1;
      mem_ack_i = 1'b0;
      @(negedge clock_i);
      checks++;
      if (ready_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL after_done: ready %b done %b want 1 0", ready_o, done_o);
      end
      for (int i = 0; i < CAP; i++) begin
         checks++;
         if (m_vld[i] !== ref_vld[i] || (ref_vld[i] && m_tag[i] !== ref_tag[i])) begin
            errors++;
            $display("FAIL table_state[%0d]: vld %b tag %h want vld %b tag %h",
                     i, m_vld[i], m_tag[i], ref_vld[i], ref_tag[i]);
         end
      end
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      repeat (2) @(posedge clock_i);
      @(negedge clock_i);
      checks++;
      if (ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", ready_o);
      end
      checks++;
      if ({done_o, hit_o, cache_addr_o, tag_search_o, tbl_wren_o, tbl_rmen_o, tbl_addr_o, tbl_tag_o,
           mem_rd_req_o, mem_addr_o, cache_wren_o, cache_waddr_o, cache_wdata_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: done %b memreq %b tag %h memaddr %h want all zero",
                  done_o, mem_rd_req_o, tag_search_o, mem_addr_o);
      end
      @(posedge clock_i); #1;
      resetn_i = 1'b1;
      for (int i = 0; i < CAP; i++) ref_vld[i] = 1'b0;
      ref_victim = 0;
      ref_hits = 0;
      ref_misses = 0;
   endtask

   task automatic test_first_miss();
      run_req(16'h0123, 0, 0);
   endtask

   task automatic test_repeat_hit();
      run_req(16'h0122, 0, 0);
   endtask

   task automatic test_victim_wrap();
      run_req(16'h1000, 0, 0);
      run_req(16'h2004, 1, 0);
      run_req(16'h3008, 0, 0);
      run_req(16'h400c, 0, 0);
      run_req(16'h0121, 0, 0);
   endtask

   task automatic test_ack_gaps();
      run_req(16'h5550, 3, 0);
      run_req(16'h6662, 3, 0);
   endtask

   task automatic test_reset_mid_fill();
      run_req(16'h7770, 1, 2);
      run_req(16'h7771, 0, 0);
      run_req(16'h0120, 0, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 30; k++)
         run_req(16'h0800 + AW'($urandom_range(0, 7) * 4) + AW'($urandom_range(0, 3)), -1, 0);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) run_req(16'h0900 + AW'(k * 4), 0, 0);
      for (int k = 0; k < 4; k++) run_req(16'h0900 + AW'(k * 4 + 1), 0, 0);
   endtask

`ifdef CACHE_MISS_STATS_EN
   task automatic test_stats();
      resetn_i = 1'b0;
      @(posedge clock_i); #1;
      resetn_i = 1'b1;
      ref_victim = 0;
      ref_hits = 0;
      ref_misses = 0;
      run_req(16'hf000, 0, 0);
      run_req(16'hf001, 0, 0);
      run_req(16'hf003, 0, 0);
      checks++;
      if (miss_count_o !== AW'(ref_misses) || hit_count_o !== AW'(ref_hits) || ref_misses != 1
          || ref_hits != 2) begin
         errors++;
         $display("FAIL stats: hits %0d misses %0d want 2 1", hit_count_o, miss_count_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_miss();
      test_repeat_hit();
      test_victim_wrap();
      test_ack_gaps();
      test_reset_mid_fill();
      test_back_to_back();
      test_random();
`ifdef CACHE_MISS_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
